// File: rtl/spi_ram_slave_p_if.sv
// SPI-to-RAM endpoint bus.
//   SS_n      : slave select, active low (host -> slave)
//   MOSI      : serial command/payload, MSB first (host -> slave)
//   MISO      : serial read data (slave -> host)
//   busy      : slave FSM not idle (slave -> host)
//   frame_err : one-cycle pulse on mid-frame SS_n release (slave -> host)
//   range_err : one-cycle pulse on out-of-range data access (slave -> host)
interface spi_ram_slave_p_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic frame_err;
  logic range_err;

  modport master (
    output SS_n, MOSI,
    input  MISO, busy, frame_err, range_err
  );

  modport slave (
    input  SS_n, MOSI,
    output MISO, busy, frame_err, range_err
  );
endinterface

// File: rtl/spi_ram_slave_p.sv
// Single-clock SPI slave with integrated single-port RAM.
// Frame: cmd[1:0] then payload[W-1:0], MSB first.
//   00 load wr_ptr, 01 write RAM[wr_ptr], 10 load rd_ptr, 11 read RAM[rd_ptr].
// Ports:
//   clk : system clock, all sampling on rising edge
//   rst : asynchronous active-high reset (RAM contents are kept)
//   bus : spi_ram_slave_p_if.slave (SS_n, MOSI, MISO, busy, frame_err, range_err)
module spi_ram_slave_p #(
  parameter int W        = 8,
  parameter int DEPTH    = 256,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  spi_ram_slave_p_if.slave  bus
);

  localparam int            CW       = $clog2(W + 2);
  localparam logic [CW-1:0] RX_LAST  = CW'(W + 1);
  localparam logic [CW-1:0] TX_LAST  = CW'(W - 2);
  localparam logic [W:0]    DEPTH_X  = (W + 1)'(DEPTH);
  localparam logic [W-1:0]  PTR_LAST = W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECV,
    EXEC,
    TX,
    DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W+1:0]   rx_sh;
  logic [W-1:0]   tx_sh;
  logic [W-1:0]   wr_ptr;
  logic [W-1:0]   rd_ptr;
  logic           miso_q;
  logic           busy_q;
  logic           frame_err_q;
  logic           range_err_q;

  logic [W-1:0]   mem [DEPTH];

  logic [1:0]     cmd;
  logic [W-1:0]   payload;
  logic           wr_ok;
  logic           rd_ok;
  logic           ram_we;
  logic [W-1:0]   rd_word;

  assign cmd     = rx_sh[W+1:W];
  assign payload = rx_sh[W-1:0];
  // Zero-extend the pointer so DEPTH == 2**W compares correctly.
  assign wr_ok   = {1'b0, wr_ptr} < DEPTH_X;
  assign rd_ok   = {1'b0, rd_ptr} < DEPTH_X;
  assign rd_word = rd_ok ? mem[rd_ptr] : '0;
  // An EXEC that sees SS_n high is an abort and must not touch the RAM.
  assign ram_we  = (state == EXEC) && !bus.SS_n && (cmd == 2'b01) && wr_ok;

  assign bus.MISO      = miso_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.range_err = range_err_q;

  // Wraps at DEPTH-1; an out-of-range pointer simply rolls modulo 2**W.
  function automatic logic [W-1:0] ptr_step(input logic [W-1:0] p);
    if (!AUTO_INC) return p;
    return (p == PTR_LAST) ? '0 : p + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_ptr] <= payload;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
      range_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.SS_n) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (bus.SS_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state <= RECV;
            cnt   <= '0;
          end
        end
        RECV: begin
          if (bus.SS_n) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end else begin
            rx_sh <= {rx_sh[W:0], bus.MOSI};
            if (cnt == RX_LAST) state <= EXEC;
            else                cnt   <= cnt + CW'(1);
          end
        end
        EXEC: begin
          if (bus.SS_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            case (cmd)
              2'b00: begin
                wr_ptr <= payload;
                state  <= DONE;
              end
              2'b01: begin
                range_err_q <= !wr_ok;
                wr_ptr      <= ptr_step(wr_ptr);
                state       <= DONE;
              end
              2'b10: begin
                rd_ptr <= payload;
                state  <= DONE;
              end
              default: begin
                // MSB goes out on this edge; the rest shifts out of tx_sh in TX.
                miso_q      <= rd_word[W-1];
                tx_sh       <= {rd_word[W-2:0], 1'b0};
                range_err_q <= !rd_ok;
                rd_ptr      <= ptr_step(rd_ptr);
                cnt         <= '0;
                state       <= TX;
              end
            endcase
          end
        end
        TX: begin
          if (bus.SS_n) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end else begin
            miso_q <= tx_sh[W-1];
            tx_sh  <= {tx_sh[W-2:0], 1'b0};
            if (cnt == TX_LAST) state <= DONE;
            else                cnt   <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.SS_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Bench for spi_ram_slave_p: three instances (DEPTH=256/AUTO_INC=1,
// DEPTH=200/AUTO_INC=1, DEPTH=256/AUTO_INC=0) checked against an
// array-based model of the command set.
module tb_spi_ram_slave_p;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] ss_n = '1;
  logic [2:0] mosi = '0;
  logic [2:0] miso;
  logic [2:0] busy_o;
  logic [2:0] fe;
  logic [2:0] re;

  int checks = 0;
  int errors = 0;

  bit [7:0] mem_m   [3][256];
  bit       known_m [3][256];
  int       wp [3];
  int       rp [3];
  int       depth_c [3] = '{256, 200, 256};
  bit       ainc_c  [3] = '{1'b1, 1'b1, 1'b0};

  spi_ram_slave_p_if bus0 ();
  spi_ram_slave_p_if bus1 ();
  spi_ram_slave_p_if bus2 ();

  assign bus0.SS_n = ss_n[0];
  assign bus0.MOSI = mosi[0];
  assign bus1.SS_n = ss_n[1];
  assign bus1.MOSI = mosi[1];
  assign bus2.SS_n = ss_n[2];
  assign bus2.MOSI = mosi[2];
  assign miso   = {bus2.MISO, bus1.MISO, bus0.MISO};
  assign busy_o = {bus2.busy, bus1.busy, bus0.busy};
  assign fe     = {bus2.frame_err, bus1.frame_err, bus0.frame_err};
  assign re     = {bus2.range_err, bus1.range_err, bus0.range_err};

  spi_ram_slave_p #(.W(8), .DEPTH(256), .AUTO_INC(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  spi_ram_slave_p #(.W(8), .DEPTH(200), .AUTO_INC(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  spi_ram_slave_p #(.W(8), .DEPTH(256), .AUTO_INC(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int step(input int d, input int p);
    if (!ainc_c[d]) return p;
    if (p == depth_c[d] - 1) return 0;
    return (p + 1) % 256;
  endfunction

  function automatic void model(input int d, input bit [1:0] cmd, input bit [7:0] pl,
                                output bit [7:0] data, output bit known, output bit rerr);
    data = '0; known = 1'b1; rerr = 1'b0;
    case (cmd)
      2'b00: wp[d] = pl;
      2'b01: begin
        if (wp[d] < depth_c[d]) begin
          mem_m[d][wp[d]]   = pl;
          known_m[d][wp[d]] = 1'b1;
        end else rerr = 1'b1;
        wp[d] = step(d, wp[d]);
      end
      2'b10: rp[d] = pl;
      default: begin
        if (rp[d] < depth_c[d]) begin
          data  = mem_m[d][rp[d]];
          known = known_m[d][rp[d]];
        end else rerr = 1'b1;
        rp[d] = step(d, rp[d]);
      end
    endcase
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      wp[d] = 0;
      rp[d] = 0;
    end
  endfunction

  // ---------------- frame driver ----------------
  // Drives one full frame and reports what was observed. Bits go out on the
  // negedge after edges 2..11 so RECV samples them on edges 3..12.
  task automatic run_frame(input int d, input bit [1:0] cmd, input bit [7:0] pl,
                           output bit [7:0] got, output bit rerr, output bit ferr,
                           output bit blo, output bit bend, output bit stray);
    bit [9:0] f;
    f = {cmd, pl};
    got = '0; rerr = 0; ferr = 0; blo = 0; bend = 0; stray = 0;
    @(negedge clk);
    ss_n[d] = 1'b0;
    mosi[d] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!busy_o[d]) blo = 1'b1;
      if (fe[d]) ferr = 1'b1;
      if (re[d]) rerr = 1'b1;
      if (miso[d]) stray = 1'b1;
      if (i >= 1 && i <= 10) mosi[d] = f[10-i];
      else                   mosi[d] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    if (!busy_o[d]) blo = 1'b1;
    if (fe[d]) ferr = 1'b1;
    if (re[d]) rerr = 1'b1;
    if (cmd == 2'b11) begin
      got[7] = miso[d];
      for (int k = 1; k < 8; k++) begin
        @(negedge clk);
        got[7-k] = miso[d];
        if (!busy_o[d]) blo = 1'b1;
        if (fe[d] || re[d]) stray = 1'b1;
      end
    end else if (miso[d]) stray = 1'b1;
    ss_n[d] = 1'b1;
    @(negedge clk);
    if (busy_o[d]) bend = 1'b1;
    if (miso[d] || fe[d] || re[d]) stray = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({miso[d], busy_o[d], fe[d], re[d]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got miso/busy/ferr/rerr=%b, want 0000", d,
                 {miso[d], busy_o[d], fe[d], re[d]});
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 3'b000) begin
      errors++;
      $display("FAIL idle_busy: got %b, want 000", busy_o);
    end
  endtask

  task automatic test_basic();
    bit [1:0] cmds [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    bit [7:0] pls  [4] = '{8'h10, 8'hA5, 8'h10, 8'h00};
    bit [7:0] got, ed;
    bit rerr, ferr, blo, bend, stray, ek, er;
    for (int i = 0; i < 4; i++) begin
      run_frame(0, cmds[i], pls[i], got, rerr, ferr, blo, bend, stray);
      model(0, cmds[i], pls[i], ed, ek, er);
      checks++;
      if ({rerr, ferr, blo, bend, stray} !== {er, 4'b0000}) begin
        errors++;
        $display("FAIL basic_flags frame%0d: got rerr/ferr/busy_lo/busy_end/stray=%b, want %b",
                 i, {rerr, ferr, blo, bend, stray}, {er, 4'b0000});
      end
      if (cmds[i] == 2'b11) begin
        checks++;
        if (got !== ed) begin
          errors++;
          $display("FAIL basic_read: got %h, want %h", got, ed);
        end
      end
    end
  endtask

  task automatic test_burst();
    bit [1:0] cmds [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
    bit [7:0] pls  [8] = '{8'hFE, 8'h11, 8'h22, 8'h33, 8'hFE, 8'h00, 8'h00, 8'h00};
    bit [7:0] got, ed;
    bit rerr, ferr, blo, bend, stray, ek, er;
    for (int i = 0; i < 8; i++) begin
      run_frame(0, cmds[i], pls[i], got, rerr, ferr, blo, bend, stray);
      model(0, cmds[i], pls[i], ed, ek, er);
      checks++;
      if ({rerr, ferr, blo, bend, stray} !== {er, 4'b0000}) begin
        errors++;
        $display("FAIL burst_flags frame%0d: got %b, want %b", i,
                 {rerr, ferr, blo, bend, stray}, {er, 4'b0000});
      end
      if (cmds[i] == 2'b11) begin
        checks++;
        if (got !== ed) begin
          errors++;
          $display("FAIL burst_read frame%0d: got %h, want %h", i, got, ed);
        end
      end
    end
    // Third word must have wrapped to address 0.
    run_frame(0, 2'b10, 8'h00, got, rerr, ferr, blo, bend, stray);
    model(0, 2'b10, 8'h00, ed, ek, er);
    run_frame(0, 2'b11, 8'h00, got, rerr, ferr, blo, bend, stray);
    model(0, 2'b11, 8'h00, ed, ek, er);
    checks++;
    if (got !== 8'h33) begin
      errors++;
      $display("FAIL burst_wrap_addr0: got %h, want 33", got);
    end
  endtask

  task automatic test_range();
    bit [1:0] cmds [11] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01,
                            2'b10, 2'b11, 2'b11, 2'b11};
    bit [7:0] pls  [11] = '{8'hC8, 8'h99, 8'hC8, 8'h00, 8'hC7, 8'h5E, 8'h6F,
                            8'hC7, 8'h00, 8'h00, 8'h00};
    bit [7:0] got, ed;
    bit rerr, ferr, blo, bend, stray, ek, er;
    for (int i = 0; i < 11; i++) begin
      run_frame(1, cmds[i], pls[i], got, rerr, ferr, blo, bend, stray);
      model(1, cmds[i], pls[i], ed, ek, er);
      checks++;
      if ({rerr, ferr, blo, bend, stray} !== {er, 4'b0000}) begin
        errors++;
        $display("FAIL range_flags frame%0d: got rerr/ferr/busy_lo/busy_end/stray=%b, want %b",
                 i, {rerr, ferr, blo, bend, stray}, {er, 4'b0000});
      end
      if (cmds[i] == 2'b11 && ek) begin
        checks++;
        if (got !== ed) begin
          errors++;
          $display("FAIL range_read frame%0d: got %h, want %h", i, got, ed);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit [9:0] f;
    bit [7:0] got, ed;
    bit rerr, ferr, blo, bend, stray, ek, er, seen;
    bit [1:0] cmds [3] = '{2'b00, 2'b01, 2'b00};
    bit [7:0] pls  [3] = '{8'h40, 8'h9C, 8'h40};
    for (int i = 0; i < 3; i++) begin
      run_frame(0, cmds[i], pls[i], got, rerr, ferr, blo, bend, stray);
      model(0, cmds[i], pls[i], ed, ek, er);
    end
    // Write-data frame cut after 5 of 10 bits.
    f = {2'b01, 8'h3B};
    @(negedge clk); ss_n[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      mosi[0] = f[9-i];
      @(negedge clk);
    end
    ss_n[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({fe[0], busy_o[0], miso[0]} !== 3'b100) begin
      errors++;
      $display("FAIL abort_pulse: got ferr/busy/miso=%b, want 100", {fe[0], busy_o[0], miso[0]});
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (fe[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_single_pulse: got extra frame_err=%b, want 0", seen);
    end
    // START abort: must be silent.
    @(negedge clk); ss_n[0] = 1'b0;
    @(negedge clk); ss_n[0] = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (fe[0] || re[0]) seen = 1'b1;
    end
    checks++;
    if ({seen, busy_o[0]} !== 2'b00) begin
      errors++;
      $display("FAIL start_abort: got err_seen/busy=%b, want 00", {seen, busy_o[0]});
    end
    // Target word unchanged, then wr_ptr still points at 0x40.
    run_frame(0, 2'b10, 8'h40, got, rerr, ferr, blo, bend, stray);
    model(0, 2'b10, 8'h40, ed, ek, er);
    run_frame(0, 2'b11, 8'h00, got, rerr, ferr, blo, bend, stray);
    model(0, 2'b11, 8'h00, ed, ek, er);
    checks++;
    if (got !== 8'h9C) begin
      errors++;
      $display("FAIL abort_ram_kept: got %h, want 9c", got);
    end
    run_frame(0, 2'b01, 8'hD7, got, rerr, ferr, blo, bend, stray);
    model(0, 2'b01, 8'hD7, ed, ek, er);
    run_frame(0, 2'b10, 8'h40, got, rerr, ferr, blo, bend, stray);
    model(0, 2'b10, 8'h40, ed, ek, er);
    run_frame(0, 2'b11, 8'h00, got, rerr, ferr, blo, bend, stray);
    model(0, 2'b11, 8'h00, ed, ek, er);
    checks++;
    if (got !== 8'hD7) begin
      errors++;
      $display("FAIL abort_wr_ptr_kept: got %h, want d7", got);
    end
  endtask

  task automatic test_random(input int d, input int n);
    bit [1:0] cmd;
    bit [7:0] pl, got, ed;
    bit rerr, ferr, blo, bend, stray, ek, er;
    for (int i = 0; i < n; i++) begin
      cmd = 2'($urandom_range(0, 3));
      pl  = 8'($urandom_range(0, 255));
      run_frame(d, cmd, pl, got, rerr, ferr, blo, bend, stray);
      model(d, cmd, pl, ed, ek, er);
      checks++;
      if ({rerr, ferr, blo, bend, stray} !== {er, 4'b0000}) begin
        errors++;
        $display("FAIL random_flags dut%0d frame%0d cmd=%b pl=%h: got %b, want %b",
                 d, i, cmd, pl, {rerr, ferr, blo, bend, stray}, {er, 4'b0000});
      end
      if (cmd == 2'b11 && ek) begin
        checks++;
        if (got !== ed) begin
          errors++;
          $display("FAIL random_read dut%0d frame%0d: got %h, want %h", d, i, got, ed);
        end
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    bit [9:0] f;
    bit [7:0] got, ed;
    bit rerr, ferr, blo, bend, stray, ek, er;
    run_frame(0, 2'b10, 8'h20, got, rerr, ferr, blo, bend, stray);
    model(0, 2'b10, 8'h20, ed, ek, er);
    f = {2'b11, 8'h00};
    @(negedge clk); ss_n[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      mosi[0] = f[9-i];
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({miso[0], busy_o[0]} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_tx: got miso/busy=%b, want 00", {miso[0], busy_o[0]});
    end
    ss_n[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_frame(0, 2'b11, 8'h00, got, rerr, ferr, blo, bend, stray);
    model(0, 2'b11, 8'h00, ed, ek, er);
    checks++;
    if ({ek, got, rerr, ferr, blo, bend, stray} !== {1'b1, ed, 5'b00000}) begin
      errors++;
      $display("FAIL read_after_reset: got data=%h flags=%b, want data=%h flags=00000 known=1",
               got, {rerr, ferr, blo, bend, stray}, ed);
    end
  endtask

  task automatic test_no_inc();
    bit [1:0] cmds [10] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11,
                            2'b10, 2'b11};
    bit [7:0] pls  [10] = '{8'h05, 8'h77, 8'h04, 8'h5A, 8'h3C, 8'h04, 8'h00, 8'h00,
                            8'h05, 8'h00};
    bit [7:0] want [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C,
                            8'h00, 8'h77};
    bit [7:0] got, ed;
    bit rerr, ferr, blo, bend, stray, ek, er;
    for (int i = 0; i < 10; i++) begin
      run_frame(2, cmds[i], pls[i], got, rerr, ferr, blo, bend, stray);
      model(2, cmds[i], pls[i], ed, ek, er);
      checks++;
      if ({rerr, ferr, blo, bend, stray} !== 5'b00000) begin
        errors++;
        $display("FAIL noinc_flags frame%0d: got %b, want 00000", i, {rerr, ferr, blo, bend, stray});
      end
      if (cmds[i] == 2'b11) begin
        checks++;
        if (got !== want[i] || ed !== want[i]) begin
          errors++;
          $display("FAIL noinc_read frame%0d: got %h, want %h", i, got, want[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst();
    test_range();
    test_abort();
    test_random(0, 40);
    test_random(1, 40);
    test_reset_mid_tx();
    test_no_inc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_slave_p.md
Name: spi_ram_slave_p

Overview:
- Parametrised single-clock SPI slave with an integrated single-port RAM, serving as the next-generation SPI-to-memory endpoint.
- Generalises address/data width and depth.
- Adds burst auto-increment of the write and read pointers, out-of-range protection and frame-abort detection.
- The host drives MOSI/SS_n synchronous to clk; the block returns read data on MISO.

Parameters:
- W, 8, address and data payload width in bits (frame = 2 + W bits).
- DEPTH, 256, RAM word count; legal range 2..2**W.
- AUTO_INC, 1, 1 = pointer post-increments after each data write/read; 0 = pointers hold.

Ports:
- clk  in  1  system clock; all sampling on rising edge.
- rst  in  1  asynchronous, active-high reset.
- SS_n  in  1  slave select, active low; one frame per assertion.
- MOSI  in  1  serial command/payload, MSB first.
- MISO  out  1  serial read data, registered.
- busy  out  1  high whenever FSM is not IDLE.
- frame_err  out  1  one-cycle pulse when SS_n rises mid-frame.
- range_err  out  1  one-cycle pulse when a data access targets address >= DEPTH.

Behaviour:
- Reset (async): FSM=IDLE; wr_ptr=0; rd_ptr=0; bit counter=0; MISO=0; busy=0; frame_err=0; range_err=0. RAM contents are not cleared.
- Frame: cmd[1:0] then payload[W-1:0], MSB first.
  - 00 = load wr_ptr.
  - 01 = write payload to RAM[wr_ptr].
  - 10 = load rd_ptr.
  - 11 = read RAM[rd_ptr]; payload is a don't-care.
- FSM states: IDLE, START, RECV, EXEC, TX, DONE.
- IDLE: on an edge with SS_n=0 -> START. MOSI is not sampled.
- START: next edge -> RECV; counter=0. MOSI is not sampled on this edge.
- RECV: each edge shifts MOSI into rx_sh; after W+2 samples -> EXEC.
- EXEC (exactly one edge): executes the command.
  - 01: if wr_ptr<DEPTH, write RAM. Otherwise, no write and pulse range_err. If AUTO_INC, wr_ptr = (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1; an out-of-range pointer still increments modulo 2**W.
  - 11: load tx_sh with RAM[rd_ptr], or 0 plus range_err if out of range. MISO = data[W-1] on this edge. rd_ptr increments under the same rule as wr_ptr. Next state TX.
  - 00/10: pointer load only; next state DONE.
  - 01: next state DONE.
- TX: W-1 edges; the k-th edge drives MISO=data[W-1-k]; after the last edge -> DONE. MISO returns to 0 on the edge leaving TX.
- DONE: holds until SS_n=1, then -> IDLE. MOSI is ignored, so a second frame requires SS_n to go high first.
- MISO is 0 in every state except EXEC-for-read/TX.
- Abort: SS_n=1 sampled in START, RECV, EXEC or TX -> IDLE on that edge. No RAM write, no pointer change, MISO=0. frame_err pulses in the following cycle for RECV/TX only; START abort is silent. An EXEC that sees SS_n=1 does not execute.
- SS_n=1 in IDLE/DONE: no error.
- Reset mid-frame: immediate IDLE. Pointers return to 0. A partially received frame has no effect.
- Read-after-write to the same address in consecutive frames returns the new data; there is no RAM read/write collision because only one access occurs per EXEC.
- Latency: RAM write visible 1 edge after the final payload bit. First MISO bit valid 1 edge after the final frame bit. Full read frame from SS_n fall = 1+1+(W+2)+1+(W-1) edges.

Test Plan (W=8, DEPTH=256, AUTO_INC=1 unless noted):
- Reset, then frames 00_0x10, 01_0xA5, 10_0x10, 11_0x00 -> MISO shifts 1010_0101 starting the edge after the last frame bit; busy high throughout each frame; no error pulses.
- Burst: set wr_ptr=0xFE, write 0x11, 0x22, 0x33; set rd_ptr=0xFE and issue three reads -> 0x11, 0x22, 0x33. Pointer wraps 0xFF->0x00 and the third word lands at RAM[0x00].
- DEPTH=200: write at wr_ptr=0xC8 -> range_err pulse, RAM unchanged; read at rd_ptr=0xC8 -> MISO all zeros plus range_err.
- SS_n raised after 5 of 10 bits of a write-data frame -> frame_err one pulse, target RAM word and wr_ptr unchanged, FSM IDLE on the next edge.
- rst asserted asynchronously mid-TX of a read -> MISO=0, busy=0 immediately; a subsequent read of address 0 works with rd_ptr=0.
- AUTO_INC=0: two successive writes 0x5A then 0x3C at wr_ptr=0x04, then read -> 0x3C; RAM[0x05] untouched.
